pattern_loader: RTL

//   Parametrised successor to the fixed four-write debug controller.
//   On a start request it streams one full pattern into the tiled cell array, one write per tile.

---
 rtl/pattern_loader_if.sv | 30 +++
 rtl/pattern_loader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pattern_loader_if.sv
// pattern_loader_if: request/response and array-write signals of the pattern loader.
// The "slave" modport is the loader itself; "master" is the debug/UI logic plus the
// array write port that drive and consume it.
interface pattern_loader_if #(
    parameter int TILES  = 4,
    parameter int TILE_W = 16
);
    localparam int POS_W = $clog2(TILES);

    logic              start;
    logic [1:0]        mode;
    logic [TILE_W-1:0] user_val;
    logic              abort;
    logic              wr_ready;
    logic [POS_W-1:0]  pos;
    logic [TILE_W-1:0] val;
    logic              write_enb;
    logic              busy;
    logic              done;

    modport master (
        output start, mode, user_val, abort, wr_ready,
        input  pos, val, write_enb, busy, done
    );

    modport slave (
        input  start, mode, user_val, abort, wr_ready,
        output pos, val, write_enb, busy, done
    );
endinterface

// File: rtl/pattern_loader.sv
// pattern_loader: on a start request streams one pattern into a tiled cell array,
// one write per tile, with a ready handshake that can stall each write.
// Optional build macro PATTERN_LOADER_LFSR_EN turns mode 10 from a fixed checkerboard
// into a pseudo-random soup driven by a 16-bit Fibonacci LFSR (taps 16,14,13,11).
module pattern_loader #(
    parameter int TILES  = 4,
    parameter int TILE_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    pattern_loader_if.slave  bus
);
    localparam int POS_W = $clog2(TILES);
    localparam logic [POS_W-1:0]  LAST_POS   = POS_W'(TILES - 1);
    localparam logic [TILE_W-1:0] CHECK_EVEN = {(TILE_W/2){2'b10}};
    localparam logic [TILE_W-1:0] CHECK_ODD  = {(TILE_W/2){2'b01}};
    localparam logic [1:0] MODE_CLEAR = 2'b00;
    localparam logic [1:0] MODE_FILL  = 2'b01;
    localparam logic [1:0] MODE_CHECK = 2'b10;
    localparam logic [1:0] MODE_USER  = 2'b11;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t            state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [TILE_W-1:0] val_q, val_d;
    logic              wen_q, wen_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        mode_q, mode_d;
    logic [TILE_W-1:0] user_q, user_d;

    logic              accept;
    logic              lastTile;
    logic [POS_W-1:0]  posNext;
    logic [TILE_W-1:0] startVal;
    logic [TILE_W-1:0] nextVal;

    assign accept   = wen_q & bus.wr_ready;
    assign lastTile = (pos_q == LAST_POS);
    assign posNext  = pos_q + POS_W'(1);

`ifdef PATTERN_LOADER_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d, lfsrStep;

    // The soup value for a tile is the LFSR state that was current when the tile was issued.
    assign lfsrStep = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    function automatic logic [TILE_W-1:0] spread(input logic [15:0] s);
        for (int b = 0; b < TILE_W; b++) begin
            spread[b] = s[b % 16];
        end
    endfunction
`endif

    // Value of tile 0, taken from the live mode/user_val inputs since they latch on the same edge.
    always_comb begin
        startVal = '0;
        case (bus.mode)
            MODE_CLEAR: startVal = '0;
            MODE_FILL:  startVal = '1;
`ifdef PATTERN_LOADER_LFSR_EN
            MODE_CHECK: startVal = spread(lfsr_q);
`else
            MODE_CHECK: startVal = CHECK_EVEN;
`endif
            MODE_USER:  startVal = bus.user_val;
            default:    startVal = '0;
        endcase
    end

    // Value of the following tile, from the latched mode so mid-load input changes have no effect.
    always_comb begin
        nextVal = '0;
        case (mode_q)
            MODE_CLEAR: nextVal = '0;
            MODE_FILL:  nextVal = '1;
`ifdef PATTERN_LOADER_LFSR_EN
            MODE_CHECK: nextVal = spread(lfsrStep);
`else
            MODE_CHECK: nextVal = posNext[0] ? CHECK_ODD : CHECK_EVEN;
`endif
            MODE_USER:  nextVal = user_q;
            default:    nextVal = '0;
        endcase
    end

    // Next-state logic: start a load, advance on each accepted write, finish or abort back to IDLE.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        val_d   = val_q;
        wen_d   = wen_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        mode_d  = mode_q;
        user_d  = user_q;
`ifdef PATTERN_LOADER_LFSR_EN
        lfsr_d  = lfsr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                    mode_d  = bus.mode;
                    user_d  = bus.user_val;
                    pos_d   = '0;
                    val_d   = startVal;
                    wen_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
`ifdef PATTERN_LOADER_LFSR_EN
                if (accept && mode_q == MODE_CHECK) begin
                    lfsr_d = lfsrStep;
                end
`endif
                if (bus.abort || (accept && lastTile)) begin
                    state_d = IDLE;
                    pos_d   = '0;
                    val_d   = '0;
                    wen_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = ~bus.abort;
                end else if (accept) begin
                    pos_d = posNext;
                    val_d = nextVal;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pos_q   <= '0;
            val_q   <= '0;
            wen_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= '0;
            user_q  <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            val_q   <= val_d;
            wen_q   <= wen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
            user_q  <= user_d;
        end
    end

`ifdef PATTERN_LOADER_LFSR_EN
    // LFSR state persists across loads so successive soups differ; the seed keeps it non-zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    assign bus.pos       = pos_q;
    assign bus.val       = val_q;
    assign bus.write_enb = wen_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
